// File: rtl/shared_mem_arbiter.sv
// N-port arbiter serialising block-wide cache-controller requests onto one main-memory port.
// Round-robin or fixed-priority grant, one transaction in flight, per-transaction watchdog.
module shared_mem_arbiter #(
  parameter int N_PORTS  = 2,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 128,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_PORTS-1:0]        req_read,
  input  logic [N_PORTS-1:0]        req_write,
  input  logic [N_PORTS*ADDR_W-1:0] req_address,
  input  logic [N_PORTS*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [N_PORTS-1:0]        req_busywait,
  output logic [N_PORTS-1:0]        grant,
  output logic                      timeout_err,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_writedata,
  input  logic [DATA_W-1:0]         mem_readdata,
  input  logic                      mem_busywait
);
  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0] NP_W = (PTR_W + 1)'(N_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wd_cnt;
  logic [N_PORTS-1:0] req_any;
  logic [PTR_W-1:0]   base;
  logic [PTR_W-1:0]   winner;
  logic               win_found;
  logic               wd_done;

  assign req_any      = req_read | req_write;
  assign req_busywait = req_any & ~((state == S_RESP) ? grant : '0);
  assign wd_done      = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign base         = (ARB_MODE == 1) ? '0 : rr_ptr;

  // Circular search starting at base; fixed priority is the same search from port 0.
  // NOTE: every always_comb output gets a default first, otherwise a path that skips
  // the assignment infers a latch.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      logic [PTR_W:0] sum;
      sum = {1'b0, base} + (PTR_W + 1)'(k);
      if (sum >= NP_W) sum = sum - NP_W;
      if (!win_found && req_any[sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        winner    = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (win_found) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (!mem_busywait || wd_done) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant         <= '0;
      rr_ptr        <= '0;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      req_readdata  <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant         <= N_PORTS'(1) << winner;
            mem_address   <= req_address[winner*ADDR_W +: ADDR_W];
            mem_writedata <= req_writedata[winner*DATA_W +: DATA_W];
            // Write wins when a port raises both strobes.
            mem_write     <= req_write[winner];
            mem_read      <= req_read[winner] & ~req_write[winner];
            if (ARB_MODE == 0)
              rr_ptr <= (winner == PTR_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
          end
        end
        S_ISSUE: wd_cnt <= '0;
        S_WAIT: begin
          if (!mem_busywait) begin
            if (mem_read) req_readdata <= mem_readdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end else if (wd_done) begin
            req_readdata <= '0;
            timeout_err  <= 1'b1;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP:  grant <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomised bench for shared_mem_arbiter: a round-robin and a fixed-priority instance, each with a
// transaction-level predictor feeding a scoreboard queue and a cycle monitor that pops and compares.
module tb_shared_mem_arbiter;
  localparam int NP  = 2;
  localparam int AW  = 6;
  localparam int DW  = 128;
  localparam int TMO = 8;

  typedef struct {
    int            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            to;
    int            issue_edge;
    int            resp_edge;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   pause = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [NP-1:0]    rd[2], wr[2], act[2], seen[2], bw_o[2], grant_o[2];
  logic [NP*AW-1:0] addr_i[2];
  logic [NP*DW-1:0] wdat_i[2];
  logic [DW-1:0]    rdat_o[2], mem_wdat[2], mem_rdat[2];
  logic             to_o[2], mem_rd[2], mem_wr[2], mem_bw[2];
  logic [AW-1:0]    mem_a[2];
  int               cur_lat[2], mcnt[2];
  logic [DW-1:0]    phys_mem[2][64];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    return {32'(a) * 32'h9E3779B1, 32'hC0DE0000 | 32'(a), ~(32'(a) * 32'h85EBCA6B), 32'h0BAD0000 + 32'(a)};
  endfunction

  // Arbitration rule: first requesting port in circular order from ptr (RR) or from 0 (fixed).
  function automatic int pick(input logic [NP-1:0] v, input int ptr, input int mode);
    for (int k = 0; k < NP; k++) begin
      int idx = (mode == 1) ? k : (ptr + k) % NP;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic new_req(input int g, input int i);
    int op = $urandom_range(3);
    act[g][i] = 1'b1;
    rd[g][i]  = (op != 2);
    wr[g][i]  = (op >= 2);
    addr_i[g][i*AW +: AW] = AW'($urandom_range(7));
    wdat_i[g][i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drop(input int g, input int i);
    act[g][i] = 1'b0;
    rd[g][i]  = 1'b0;
    wr[g][i]  = 1'b0;
  endtask

  task automatic reset_check(input int g);
    check($sformatf("i%0d rst grant", g), DW'(grant_o[g]), '0);
    check($sformatf("i%0d rst timeout_err", g), DW'(to_o[g]), '0);
    check($sformatf("i%0d rst mem_read", g), DW'(mem_rd[g]), '0);
    check($sformatf("i%0d rst mem_write", g), DW'(mem_wr[g]), '0);
    check($sformatf("i%0d rst mem_address", g), DW'(mem_a[g]), '0);
    check($sformatf("i%0d rst mem_writedata", g), mem_wdat[g], '0);
    check($sformatf("i%0d rst readdata", g), rdat_o[g], '0);
    check($sformatf("i%0d rst busywait", g), DW'(bw_o[g]), DW'(rd[g] | wr[g]));
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    int            edge_n = 0;
    logic [DW-1:0] model_mem[64];
    txn_t          q[$];

    shared_mem_arbiter #(
      .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(g), .TIMEOUT(TMO)
    ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_read(rd[g]), .req_write(wr[g]),
      .req_address(addr_i[g]), .req_writedata(wdat_i[g]),
      .req_readdata(rdat_o[g]), .req_busywait(bw_o[g]), .grant(grant_o[g]),
      .timeout_err(to_o[g]),
      .mem_read(mem_rd[g]), .mem_write(mem_wr[g]),
      .mem_address(mem_a[g]), .mem_writedata(mem_wdat[g]),
      .mem_readdata(mem_rdat[g]), .mem_busywait(mem_bw[g])
    );

    // Memory: stalls from the cycle it sees a strobe until cur_lat WAIT cycles have passed.
    assign mem_bw[g]   = (mem_rd[g] | mem_wr[g]) && (mcnt[g] <= cur_lat[g]);
    assign mem_rdat[g] = phys_mem[g][mem_a[g]];

    initial begin
      for (int a = 0; a < 64; a++) phys_mem[g][a] = init_word(a);
      forever begin
        @(posedge clk);
        mcnt[g] <= (mem_rd[g] | mem_wr[g]) ? mcnt[g] + 1 : 0;
        if (mem_wr[g] && !mem_bw[g]) phys_mem[g][mem_a[g]] <= mem_wdat[g];
      end
    end

    // Predictor: decides each transaction's winner, latency, timing and response.
    initial begin
      int            ptr, free_edge, pw_edge, w, lat, wait_len;
      bit            pw_valid;
      logic [AW-1:0] pw_a;
      logic [DW-1:0] pw_d, last_rd;
      txn_t          t;
      ptr = 0; free_edge = 0; pw_valid = 0; pw_edge = 0; pw_a = '0; pw_d = '0; last_rd = '0;
      for (int a = 0; a < 64; a++) model_mem[a] = init_word(a);
      forever begin
        @(posedge clk);
        edge_n++;
        if (pw_valid && edge_n > pw_edge) begin
          model_mem[pw_a] = pw_d;
          pw_valid = 0;
        end
        if (!reset_n) begin
          q.delete();
          ptr = 0; free_edge = 0; pw_valid = 0; last_rd = '0;
        end else if (edge_n >= free_edge && (rd[g] | wr[g]) != '0) begin
          w   = pick(rd[g] | wr[g], ptr, g);
          lat = ($urandom_range(4) == 0) ? 7 + $urandom_range(3) : $urandom_range(5);
          cur_lat[g] <= lat;
          t.port  = w;
          t.wr    = wr[g][w];
          t.addr  = addr_i[g][w*AW +: AW];
          t.wdata = wdat_i[g][w*DW +: DW];
          t.to    = (lat >= TMO);
          wait_len = t.to ? TMO : lat + 1;
          t.issue_edge = edge_n;
          t.resp_edge  = edge_n + 1 + wait_len;
          if (t.to) last_rd = '0;
          else if (!t.wr) last_rd = model_mem[t.addr];
          t.rdata = last_rd;
          if (t.wr && !t.to) begin
            pw_valid = 1; pw_edge = t.resp_edge; pw_a = t.addr; pw_d = t.wdata;
          end
          ptr = (w + 1) % NP;
          free_edge = t.resp_edge + 2;
          q.push_back(t);
        end
      end
    end

    // Monitor: compares the cycle's outputs with the scoreboard head, pops it in RESP.
    initial begin
      txn_t          h;
      bit            in_txn, is_resp;
      logic [NP-1:0] eg;
      forever begin
        @(negedge clk);
        if (reset_n) begin
          in_txn  = (q.size() > 0);
          if (in_txn) h = q[0];
          eg      = in_txn ? NP'(1) << h.port : '0;
          is_resp = in_txn && (edge_n == h.resp_edge);
          check($sformatf("i%0d grant @%0d", g, edge_n), DW'(grant_o[g]), DW'(eg));
          check($sformatf("i%0d timeout_err @%0d", g, edge_n), DW'(to_o[g]), DW'(is_resp && h.to));
          check($sformatf("i%0d busywait @%0d", g, edge_n), DW'(bw_o[g]),
                DW'((rd[g] | wr[g]) & ~(is_resp ? eg : '0)));
          check($sformatf("i%0d mem_read @%0d", g, edge_n), DW'(mem_rd[g]),
                DW'(in_txn && !is_resp && !h.wr));
          check($sformatf("i%0d mem_write @%0d", g, edge_n), DW'(mem_wr[g]),
                DW'(in_txn && !is_resp && h.wr));
          if (in_txn && edge_n == h.issue_edge) begin
            check($sformatf("i%0d mem_address @%0d", g, edge_n), DW'(mem_a[g]), DW'(h.addr));
            if (h.wr) check($sformatf("i%0d mem_writedata @%0d", g, edge_n), mem_wdat[g], h.wdata);
          end
          if (is_resp) begin
            check($sformatf("i%0d readdata @%0d", g, edge_n), rdat_o[g], h.rdata);
            void'(q.pop_front());
          end
        end
      end
    end

    // Requesters: react to their own RESP, occasionally abandon or scramble inputs mid-flight.
    always @(negedge clk) seen[g] = act[g] & ~bw_o[g];

    initial begin
      forever begin
        @(posedge clk);
        #2;
        if (!pause) begin
          for (int i = 0; i < NP; i++) begin
            if (seen[g][i]) begin
              seen[g][i] = 1'b0;
              if ($urandom_range(3) != 0) new_req(g, i);
              else drop(g, i);
            end else if (!act[g][i]) begin
              if ($urandom_range(2) == 0) new_req(g, i);
            end else if ($urandom_range(31) == 0) begin
              drop(g, i);
            end else if ($urandom_range(3) == 0) begin
              addr_i[g][i*AW +: AW] = AW'($urandom_range(7));
              wdat_i[g][i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            end
          end
        end
      end
    end
  end

  initial begin
    int streak;
    bit found;
    for (int g = 0; g < 2; g++) begin
      rd[g] = '0; wr[g] = '0; act[g] = '0; seen[g] = '0;
      addr_i[g] = '0; wdat_i[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) reset_check(g);
    @(negedge clk);
    #2 reset_n = 1'b1;
    pause = 1'b0;
    repeat (1500) @(posedge clk);

    // Reset while instance 0 is stalled in WAIT.
    streak = 0;
    found  = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (mem_bw[0] && (mem_rd[0] | mem_wr[0])) streak++;
      else streak = 0;
      found = (streak >= 2);
    end
    check("wait_reached", DW'(found), DW'(1));
    pause = 1'b1;
    #2 reset_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rd[g] = '1; wr[g] = '0; act[g] = '1; seen[g] = '0;
    end
    #1;
    for (int g = 0; g < 2; g++) reset_check(g);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check($sformatf("i%0d grant after reset", g), DW'(grant_o[g]), DW'(1));
    pause = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
